// File: rtl/av_pkg.sv
// Shared constants for the video-locked audio engine: DAC mode codes,
// default widths and a ceiling-log2 helper for sizing the mixer.
package av_pkg;

   typedef enum int {
      DAC_PWM = 0,
      DAC_SD  = 1
   } dac_mode_e;

   localparam int AV_NUM_CH   = 4;
   localparam int AV_SAMPLE_W = 8;
   localparam int AV_DIV_W    = 10;
   localparam int AV_VOL_W    = 4;

   function automatic int av_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/audio_tone_ch.sv
// One square-wave tone channel: half-period counter in line ticks, a phase
// bit, and the volume-scaled contribution that the phase gates onto the mix.
module audio_tone_ch
   import av_pkg::*;
#(
   parameter int SAMPLE_W = AV_SAMPLE_W,
   parameter int DIV_W    = AV_DIV_W,
   parameter int VOL_W    = AV_VOL_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                strobe_i,
   input  logic                en_i,
   input  logic [DIV_W-1:0]    div_i,
   input  logic [VOL_W-1:0]    vol_i,
   output logic [SAMPLE_W-1:0] contrib_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic             phase_q;
   logic             phase_d;
   logic             run;

   assign run = en_i && (div_i != '0);

   // A disabled or zero-period channel parks immediately, strobe or not;
   // >= lets a shrinking period take effect on the very next tick.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!run) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (strobe_i) begin
         if (cnt_q >= (div_i - DIV_W'(1))) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign contrib_o = phase_q ? (SAMPLE_W'(vol_i) << (SAMPLE_W - VOL_W)) : '0;

endmodule

// File: rtl/av_audio_engine.sv
// Multi-channel square-wave synth locked to the VGA line rate: per-channel
// tone generators, saturating mixer, and a PWM or sigma-delta 1-bit DAC.
module av_audio_engine
   import av_pkg::*;
#(
   parameter int NUM_CH   = AV_NUM_CH,
   parameter int SAMPLE_W = AV_SAMPLE_W,
   parameter int DIV_W    = AV_DIV_W,
   parameter int VOL_W    = AV_VOL_W,
   parameter int DAC_MODE = DAC_PWM
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     line_strobe,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [NUM_CH*DIV_W-1:0]  ch_div,
   input  logic [NUM_CH*VOL_W-1:0]  ch_vol,
   input  logic                     mute,
   output logic [SAMPLE_W-1:0]      sample_out,
   output logic                     sample_valid,
   output logic                     pwm_out
);

   localparam int MIX_W = SAMPLE_W + av_clog2(NUM_CH);

   function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [MIX_W-1:0] x);
      if ((x >> SAMPLE_W) != '0) begin
         return '1;
      end
      return x[SAMPLE_W-1:0];
   endfunction

   logic [SAMPLE_W-1:0] contrib [NUM_CH];
   logic [MIX_W-1:0]    mix_sum;
   logic [SAMPLE_W-1:0] sample_q;
   logic [SAMPLE_W-1:0] sample_d;
   logic                vld_p1_q;
   logic                vld_p2_q;

   // Stage 0: channel state advances on the edge that samples line_strobe
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      audio_tone_ch #(
         .SAMPLE_W (SAMPLE_W),
         .DIV_W    (DIV_W),
         .VOL_W    (VOL_W)
      ) u_ch (
         .clk_i     (clk),
         .rst_i     (rst),
         .strobe_i  (line_strobe),
         .en_i      (ch_en[k]),
         .div_i     (ch_div[k*DIV_W +: DIV_W]),
         .vol_i     (ch_vol[k*VOL_W +: VOL_W]),
         .contrib_o (contrib[k])
      );
   end

   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mix_sum = mix_sum + MIX_W'(contrib[i]);
      end
   end

   // Stage 1: mix the freshly updated phases and register the sample
   always_comb begin
      sample_d = sample_q;
      if (vld_p1_q) begin
         sample_d = mute ? '0 : sat_sample(mix_sum);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         sample_q <= '0;
      end else begin
         vld_p1_q <= line_strobe;
         vld_p2_q <= vld_p1_q;
         sample_q <= sample_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = vld_p2_q;

   // Stage 2: 1-bit DAC running every clock from the held sample
   if (DAC_MODE == DAC_SD) begin : g_sd
      logic [SAMPLE_W:0] acc_q;
      logic [SAMPLE_W:0] acc_d;

      assign acc_d = {1'b0, acc_q[SAMPLE_W-1:0]} + {1'b0, sample_q};

      always_ff @(posedge clk) begin
         if (rst) begin
            acc_q <= '0;
         end else begin
            acc_q <= acc_d;
         end
      end

      assign pwm_out = acc_q[SAMPLE_W];
   end else begin : g_pwm
      logic [SAMPLE_W-1:0] pcnt_q;
      logic [SAMPLE_W-1:0] pcnt_d;
      logic [SAMPLE_W-1:0] duty_q;
      logic [SAMPLE_W-1:0] duty_d;
      logic                pwm_q;

      // Duty only reloads at the period start so a period is never split
      assign pcnt_d = pcnt_q + SAMPLE_W'(1);
      assign duty_d = (pcnt_q == '0) ? sample_q : duty_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            pcnt_q <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
         end else begin
            pcnt_q <= pcnt_d;
            duty_q <= duty_d;
            pwm_q  <= (pcnt_q < duty_d);
         end
      end

      assign pwm_out = pwm_q;
   end

endmodule

// File: tb/tb_av_audio_engine.sv
// Bench for av_audio_engine: a PWM and a sigma-delta instance share stimulus;
// a behavioural channel model feeds an expected-sample queue.
module tb_av_audio_engine;

   localparam int NUM_CH   = 4;
   localparam int SAMPLE_W = 8;
   localparam int DIV_W    = 10;
   localparam int VOL_W    = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    line_strobe;
   logic [NUM_CH-1:0]       ch_en;
   logic [NUM_CH*DIV_W-1:0] ch_div;
   logic [NUM_CH*VOL_W-1:0] ch_vol;
   logic                    mute;
   logic [SAMPLE_W-1:0]     s0, s1;
   logic                    v0, v1, p0, p1;

   always #5 clk = ~clk;

   av_audio_engine #(
      .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DIV_W(DIV_W), .VOL_W(VOL_W), .DAC_MODE(0)
   ) dut_pwm (
      .clk(clk), .rst(rst), .line_strobe(line_strobe), .ch_en(ch_en), .ch_div(ch_div),
      .ch_vol(ch_vol), .mute(mute), .sample_out(s0), .sample_valid(v0), .pwm_out(p0)
   );

   av_audio_engine #(
      .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DIV_W(DIV_W), .VOL_W(VOL_W), .DAC_MODE(1)
   ) dut_sd (
      .clk(clk), .rst(rst), .line_strobe(line_strobe), .ch_en(ch_en), .ch_div(ch_div),
      .ch_vol(ch_vol), .mute(mute), .sample_out(s1), .sample_valid(v1), .pwm_out(p1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int unsigned smp;
      int unsigned stamp;
   } exp_t;

   exp_t        sb[$];
   int unsigned m_cnt [NUM_CH];
   bit          m_ph  [NUM_CH];
   bit          pend;
   int unsigned edge_no   = 0;
   int unsigned since_rst = 0;
   int unsigned md, mv, msum;

   // Reference channel/mixer model, evaluated on the same edges as the DUT
   always @(posedge clk) begin
      edge_no++;
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            m_cnt[k] = 0;
            m_ph[k]  = 1'b0;
         end
         pend      = 1'b0;
         since_rst = 0;
      end else begin
         since_rst++;
         if (pend) begin
            msum = 0;
            for (int k = 0; k < NUM_CH; k++) begin
               mv = ch_vol[k*VOL_W +: VOL_W];
               if (m_ph[k]) msum += mv << (SAMPLE_W - VOL_W);
            end
            if (msum > 255) msum = 255;
            if (mute) msum = 0;
            sb.push_back('{smp: msum, stamp: edge_no});
         end
         pend = line_strobe;
         for (int k = 0; k < NUM_CH; k++) begin
            md = ch_div[k*DIV_W +: DIV_W];
            if (!ch_en[k] || md == 0) begin
               m_cnt[k] = 0;
               m_ph[k]  = 1'b0;
            end else if (line_strobe) begin
               if (m_cnt[k] >= md - 1) begin
                  m_cnt[k] = 0;
                  m_ph[k]  = ~m_ph[k];
               end else begin
                  m_cnt[k] = m_cnt[k] + 1;
               end
            end
         end
      end
   end

   exp_t e;
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].stamp == edge_no) begin
         e = sb.pop_front();
         chk("valid", {31'd0, v0}, 1);
         chk("valid_sd", {31'd0, v1}, 1);
         chk("sample", {24'd0, s0}, e.smp);
         chk("sample_sd", {24'd0, s1}, e.smp);
      end else begin
         if (v0) chk("valid_spurious", {31'd0, v0}, 0);
         if (v1) chk("valid_spurious_sd", {31'd0, v1}, 0);
      end
   end

   task automatic pulse(input int gap);
      line_strobe = 1'b1;
      @(negedge clk);
      line_strobe = 1'b0;
      for (int i = 1; i < gap; i++) @(negedge clk);
   endtask

   task automatic set_ch(input int k, input bit en, input int div, input int vol);
      ch_en[k]                 = en;
      ch_div[k*DIV_W +: DIV_W] = DIV_W'(div);
      ch_vol[k*VOL_W +: VOL_W] = VOL_W'(vol);
   endtask

   task automatic clear_chs();
      ch_en = '0;
      @(negedge clk);
   endtask

   task automatic count_window(input int strobe_at, input int new_vol,
                               output int ones0, output int ones1);
      ones0 = 0;
      ones1 = 0;
      for (int i = 0; i < 256; i++) begin
         ones0 += int'(p0);
         ones1 += int'(p1);
         if (i == strobe_at) begin
            ch_vol[0 +: VOL_W] = VOL_W'(new_vol);
            line_strobe = 1'b1;
         end else begin
            line_strobe = 1'b0;
         end
         @(negedge clk);
      end
      line_strobe = 1'b0;
   endtask

   int t2_exp [9] = '{'h00, 'h00, 'hF0, 'hF0, 'hF0, 'h00, 'h00, 'h00, 'hF0};
   int o0, o1, tog;
   logic prev;

   initial begin
      rst = 1'b1; line_strobe = 1'b0; ch_en = '0; ch_div = '0; ch_vol = '0; mute = 1'b0;

      // Reset held with strobes toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_sample", {24'd0, s0}, 0);
         chk("rst_valid", {31'd0, v0}, 0);
         chk("rst_pwm", {31'd0, p0}, 0);
         chk("rst_pwm_sd", {31'd0, p1}, 0);
         line_strobe = ~line_strobe;
      end
      line_strobe = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // Single tone, div=3
      set_ch(0, 1, 3, 15);
      for (int i = 0; i < 9; i++) begin
         pulse(4);
         chk("tone_div3", {24'd0, s0}, t2_exp[i]);
      end

      // Saturation with four channels in phase
      clear_chs();
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 1, 1, 15);
      pulse(4); chk("sat_hi", {24'd0, s0}, 'hFF);
      pulse(4); chk("sat_lo", {24'd0, s0}, 'h00);
      pulse(4); chk("sat_hi2", {24'd0, s0}, 'hFF);

      // Period shortened below the running count
      clear_chs();
      set_ch(0, 1, 10, 15);
      for (int i = 0; i < 5; i++) pulse(3);
      chk("div10_quiet", {24'd0, s0}, 'h00);
      set_ch(0, 1, 2, 15);
      pulse(3);
      chk("div_drop", {24'd0, s0}, 'hF0);

      // Enable dropped for a single cycle clears phase and count
      ch_en[0] = 1'b0;
      @(negedge clk);
      ch_en[0] = 1'b1;
      pulse(3);
      chk("en_drop", {24'd0, s0}, 'h00);

      // Mute forces zero while phases keep toggling
      clear_chs();
      set_ch(0, 1, 1, 15);
      mute = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pulse(3);
         chk("muted", {24'd0, s0}, 'h00);
      end
      mute = 1'b0;
      pulse(3);
      chk("unmuted", {24'd0, s0}, 'hF0);

      // Reset while a sample is in flight
      clear_chs();
      set_ch(0, 1, 1, 15);
      line_strobe = 1'b1;
      @(negedge clk);
      line_strobe = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", {31'd0, v0}, 0);
      chk("rst_mid_sample", {24'd0, s0}, 0);
      chk("rst_mid_pwm", {31'd0, p0}, 0);
      rst = 1'b0;
      pulse(3);
      chk("post_rst", {24'd0, s0}, 'hF0);

      // PWM / sigma-delta density with sample 0x40, then 0x80
      clear_chs();
      set_ch(0, 1, 1, 4);
      pulse(3);
      set_ch(0, 1, 1023, 4);
      @(negedge clk);
      for (int i = 0; i < 600 && (since_rst % 256) != 1; i++) @(negedge clk);
      chk("pwm_align", since_rst % 256, 1);
      count_window(-1, 4, o0, o1);
      chk("pwm_0x40", o0, 64);
      chk("sd_0x40", o1, 64);
      count_window(100, 8, o0, o1);
      chk("pwm_midchange", o0, 64);
      count_window(-1, 8, o0, o1);
      chk("pwm_0x80", o0, 128);
      chk("sd_0x80", o1, 128);

      // Sigma-delta at half scale alternates every clock
      tog = 0;
      prev = p1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (p1 != prev) tog++;
         prev = p1;
      end
      chk("sd_toggle", tog, 32);

      // Zero sample silences both DACs
      ch_vol[0 +: VOL_W] = '0;
      pulse(3);
      chk("zero_sample", {24'd0, s0}, 0);
      for (int i = 0; i < 300; i++) @(negedge clk);
      count_window(-1, 0, o0, o1);
      chk("pwm_zero", o0, 0);
      chk("sd_zero", o1, 0);

      repeat (4) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
